// File: rtl/ht_dec_if.sv
// Stream-side bundle of the canonical-Huffman decoder: table load, bit input, symbol output.
// The master drives the table and bitstream; the slave is the decoder.
interface ht_dec_if #(
  parameter int index = 8,
  parameter int width = 4
) ();
  localparam int index_width = $clog2(index);

  logic                   start;
  logic [width-1:0]       lens [0:index-1];
  logic                   over;
  logic                   err;
  logic                   bit_in;
  logic                   bit_valid;
  logic                   bit_ready;
  logic [index_width-1:0] sym_out;
  logic                   sym_valid;
  logic                   sym_ready;

  modport master (
    output start, lens, bit_in, bit_valid, sym_ready,
    input  over, err, bit_ready, sym_out, sym_valid
  );

  modport slave (
    input  start, lens, bit_in, bit_valid, sym_ready,
    output over, err, bit_ready, sym_out, sym_valid
  );
endinterface

// File: rtl/ht_dec.sv
// Canonical-Huffman decoder: builds count/offset/sorted tables from per-symbol code lengths,
// then decodes a serial MSB-first bitstream into symbol indices, one bit per cycle.
module ht_dec #(
  parameter int index       = 8,
  parameter int width       = 4,
  parameter int index_width = $clog2(index),
  parameter int max_len     = 7
) (
  input  logic     clk,
  input  logic     rst,
  ht_dec_if.slave  bus
);
  localparam int LW  = $clog2(max_len + 1);
  localparam int CW  = index_width + 1;
  localparam int KW  = max_len + 1;
  localparam int KW1 = KW + 1;
  localparam int SW  = $clog2(index + max_len) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_OFFS, S_PLACE, S_DECODE, S_ERR
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SW-1:0]          r_step;
  logic [CW-1:0]          r_count  [0:2**LW-1];
  logic [CW-1:0]          r_offs   [0:2**LW-1];
  logic [index_width-1:0] r_sorted [0:index-1];
  logic [CW-1:0]          r_sum;
  logic [KW-1:0]          r_left;
  logic                   r_bad;
  logic [KW-1:0]          r_code;
  logic [KW-1:0]          r_first;
  logic [CW-1:0]          r_idx;
  logic [LW-1:0]          r_len;
  logic                   r_sym_valid;
  logic [index_width-1:0] r_sym_out;

  logic                   w_over;
  logic                   w_err;
  logic                   w_bit_ready;
  logic                   w_last_index;
  logic                   w_last_offs;
  logic [width-1:0]       w_lens_cur;
  logic                   w_len_ok;
  logic [LW-1:0]          w_len_idx;
  logic [LW-1:0]          w_l;
  logic [CW-1:0]          w_cnt_l;
  logic [KW1-1:0]         w_left2;
  logic                   w_oversub;
  logic [CW-1:0]          w_sum_l;
  logic                   w_bit_hs;
  logic [KW-1:0]          w_c;
  logic [KW-1:0]          w_f;
  logic [KW-1:0]          w_d;
  logic [LW-1:0]          w_len_n;
  logic [CW-1:0]          w_cnt;
  logic                   w_match;
  logic                   w_dead;
  logic [index_width-1:0] w_sel;

  // r_step walks symbols in COUNT/PLACE and lengths (minus one) in OFFS.
  assign w_last_index = (r_step == SW'(index - 1));
  assign w_last_offs  = (r_step == SW'(max_len - 1));
  assign w_lens_cur   = bus.lens[r_step[index_width-1:0]];
  assign w_len_ok     = (w_lens_cur <= width'(max_len));
  assign w_len_idx    = w_lens_cur[LW-1:0];

  assign w_l       = LW'(r_step + 1'b1);
  assign w_cnt_l   = r_count[w_l];
  assign w_left2   = {r_left, 1'b0};
  assign w_oversub = (w_left2 < KW1'(w_cnt_l));
  assign w_sum_l   = r_sum + w_cnt_l;

  assign w_bit_hs = w_bit_ready && bus.bit_valid;
  assign w_c      = {r_code[KW-2:0], bus.bit_in};
  assign w_f      = {r_first[KW-2:0], 1'b0};
  assign w_d      = w_c - w_f;
  assign w_len_n  = r_len + 1'b1;
  assign w_cnt    = r_count[w_len_n];
  assign w_match  = (w_c >= w_f) && (w_d < KW'(w_cnt));
  assign w_dead   = !w_match && (w_len_n == LW'(max_len));
  assign w_sel    = r_idx[index_width-1:0] + w_d[index_width-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_COUNT:  if (w_last_index) w_state_next = S_OFFS;
      S_OFFS:   if (w_last_offs) w_state_next = S_PLACE;
      S_PLACE:  if (w_last_index) w_state_next = r_bad ? S_ERR : S_DECODE;
      S_DECODE: if (w_bit_hs && w_dead) w_state_next = S_ERR;
      default:  ;
    endcase
    if (bus.start) w_state_next = S_COUNT;
  end

  always_comb begin
    w_over      = (r_state == S_DECODE);
    w_err       = (r_state == S_ERR);
    w_bit_ready = (r_state == S_DECODE) && (!r_sym_valid || bus.sym_ready);
  end

  assign bus.over      = w_over;
  assign bus.err       = w_err;
  assign bus.bit_ready = w_bit_ready;
  assign bus.sym_out   = r_sym_out;
  assign bus.sym_valid = r_sym_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step      <= '0;
      r_sum       <= '0;
      r_left      <= '0;
      r_bad       <= 1'b0;
      r_code      <= '0;
      r_first     <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_sym_valid <= 1'b0;
      r_sym_out   <= '0;
      for (int k = 0; k < 2**LW; k++) begin
        r_count[k] <= '0;
        r_offs[k]  <= '0;
      end
      for (int k = 0; k < index; k++) r_sorted[k] <= '0;
    end else begin
      if (bus.start || (r_state != w_state_next)) r_step <= '0;
      else                                        r_step <= r_step + 1'b1;

      if (bus.start) begin
        r_sum       <= '0;
        r_left      <= KW'(1);
        r_bad       <= 1'b0;
        r_code      <= '0;
        r_first     <= '0;
        r_idx       <= '0;
        r_len       <= '0;
        r_sym_valid <= 1'b0;
        for (int k = 0; k < 2**LW; k++) begin
          r_count[k] <= '0;
          r_offs[k]  <= '0;
        end
      end else begin
        case (r_state)
          S_COUNT: begin
            if (!w_len_ok)             r_bad <= 1'b1;
            else if (w_lens_cur != '0) r_count[w_len_idx] <= r_count[w_len_idx] + 1'b1;
          end
          S_OFFS: begin
            // Kraft: unused leaves at depth L are twice those at L-1 minus codes of length L.
            r_offs[w_l] <= r_sum;
            r_sum       <= w_sum_l;
            r_left      <= w_left2[KW-1:0] - KW'(w_cnt_l);
            if (w_oversub || (w_last_offs && (w_sum_l == '0))) r_bad <= 1'b1;
          end
          S_PLACE: begin
            if (!r_bad && (w_lens_cur != '0)) begin
              r_sorted[r_offs[w_len_idx][index_width-1:0]] <= r_step[index_width-1:0];
              r_offs[w_len_idx] <= r_offs[w_len_idx] + 1'b1;
            end
          end
          S_DECODE: begin
            if (w_bit_hs && w_match) begin
              r_sym_out   <= r_sorted[w_sel];
              r_sym_valid <= 1'b1;
              r_code      <= '0;
              r_first     <= '0;
              r_idx       <= '0;
              r_len       <= '0;
            end else begin
              if (r_sym_valid && bus.sym_ready) r_sym_valid <= 1'b0;
              if (w_bit_hs) begin
                r_idx   <= r_idx + w_cnt;
                r_first <= w_f + KW'(w_cnt);
                r_code  <= w_c;
                r_len   <= w_len_n;
              end
            end
          end
          S_ERR:   r_sym_valid <= 1'b0;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ht_dec.sv
// Self-checking bench for ht_dec: table-build latency, decode order via a symbol scoreboard,
// error detection, backpressure, abort and asynchronous reset.
module tb_ht_dec;
  localparam int IDX   = 8;
  localparam int W     = 4;
  localparam int IW    = 3;
  localparam int ML    = 7;
  localparam int BUILD = 2 * IDX + ML;
  // Tables packed one nibble per symbol, lens[0] in the least significant nibble.
  localparam logic [31:0] T_BASIC  = 32'h0000_3312;
  localparam logic [31:0] T_OVER   = 32'h0000_0111;
  localparam logic [31:0] T_BADLEN = 32'h0080_3312;
  localparam logic [31:0] T_ZERO   = 32'h0000_0000;
  localparam logic [31:0] T_SHORT  = 32'h0000_0021;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ht_dec_if #(.index(IDX), .width(W)) bus ();
  ht_dec #(.index(IDX), .width(W), .index_width(IW), .max_len(ML)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int exp_q[$];
  int mon_exp;
  int sv_seen = 0;

  always @(negedge clk) begin
    if (bus.sym_valid) sv_seen++;
    if (!rst && bus.sym_valid && bus.sym_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sym_unexpected: got %0d, required no symbol", bus.sym_out);
      end else begin
        mon_exp = exp_q.pop_front();
        $display("sym_out=%0d expected=%0d", bus.sym_out, mon_exp);
        if (bus.sym_out !== IW'(mon_exp)) begin
          n_bad++;
          $display("FAIL sym_value: got %0d, required %0d", bus.sym_out, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [31:0] tbl, output int cyc, output logic over0);
    for (int i = 0; i < IDX; i++) bus.lens[i] = tbl[i*W +: W];
    bus.bit_valid = 1'b0;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    over0 = bus.over;
    cyc = 0;
    while (!(bus.over || bus.err) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 100) cyc = -1;
  endtask

  task automatic send_bit(input logic b);
    int t = 0;
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    @(negedge clk);
    while (!bus.bit_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_vec++;
      n_bad++;
      $display("FAIL bit_timeout: bit_ready stayed 0, required 1");
    end
    @(posedge clk); #1;
    bus.bit_valid = 1'b0;
  endtask

  task automatic check_build(input string name, input int cyc, input logic exp_over);
    n_vec++;
    if (cyc !== BUILD) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, cyc, BUILD);
    end
    n_vec++;
    if (bus.over !== exp_over || bus.err !== !exp_over) begin
      n_bad++;
      $display("FAIL %s_status: got over=%b err=%b, required over=%b err=%b",
               name, bus.over, bus.err, exp_over, !exp_over);
    end
  endtask

  task automatic check_drained(input string name);
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d symbols outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.over, bus.err, bus.bit_ready, bus.sym_valid} !== 4'b0 || bus.sym_out !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got over=%b err=%b bit_ready=%b sym_valid=%b sym_out=%0d, required all 0",
               bus.over, bus.err, bus.bit_ready, bus.sym_valid, bus.sym_out);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (bus.over !== 1'b0 || bus.err !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_status: got over=%b err=%b, required 0 0", bus.over, bus.err);
    end
  endtask

  task automatic test_basic();
    int cyc;
    logic ov0;
    int bits[9] = '{0, 1, 0, 1, 1, 1, 1, 1, 0};
    int last[9] = '{1, 0, 1, 0, 0, 1, 0, 0, 1};
    do_start(T_BASIC, cyc, ov0);
    check_build("basic", cyc, 1'b1);
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(2);
    for (int i = 0; i < 9; i++) begin
      send_bit(bits[i][0]);
      n_vec++;
      if (bus.sym_valid !== last[i][0]) begin
        n_bad++;
        $display("FAIL basic_valid_timing bit %0d: got sym_valid=%b, required %0d", i, bus.sym_valid, last[i]);
      end
    end
    check_drained("basic");
  endtask

  task automatic test_bad_table(input string name, input logic [31:0] tbl);
    int cyc;
    logic ov0;
    do_start(tbl, cyc, ov0);
    check_build(name, cyc, 1'b0);
    n_vec++;
    if (bus.bit_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_bit_ready: got %b, required 0", name, bus.bit_ready);
    end
  endtask

  task automatic test_undecodable();
    int cyc;
    logic ov0;
    do_start(T_SHORT, cyc, ov0);
    check_build("short", cyc, 1'b1);
    sv_seen = 0;
    for (int i = 1; i <= 7; i++) begin
      send_bit(1'b1);
      n_vec++;
      if (bus.err !== (i == 7)) begin
        n_bad++;
        $display("FAIL undecodable_err bit %0d: got err=%b, required %0d", i, bus.err, (i == 7));
      end
    end
    n_vec++;
    if (bus.bit_ready !== 1'b0 || bus.over !== 1'b0) begin
      n_bad++;
      $display("FAIL undecodable_outputs: got bit_ready=%b over=%b, required 0 0", bus.bit_ready, bus.over);
    end
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (sv_seen != 0) begin
      n_bad++;
      $display("FAIL undecodable_sym_valid: sym_valid seen %0d cycles, required 0", sv_seen);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    logic ov0;
    int bits[8] = '{1, 0, 1, 1, 1, 1, 1, 0};
    do_start(T_BASIC, cyc, ov0);
    check_build("bp", cyc, 1'b1);
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(2);
    bus.sym_ready = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (bus.sym_valid !== 1'b1 || bus.sym_out !== IW'(1) || bus.bit_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold cycle %0d: got sym_valid=%b sym_out=%0d bit_ready=%b, required 1 1 0",
                 i, bus.sym_valid, bus.sym_out, bus.bit_ready);
      end
    end
    bus.sym_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(bits[i][0]);
    check_drained("bp");
  endtask

  task automatic test_abort();
    int cyc;
    logic ov0;
    send_bit(1'b1);
    send_bit(1'b1);
    do_start(T_BASIC, cyc, ov0);
    n_vec++;
    if (ov0 !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_over_drop: got over=%b after start edge, required 0", ov0);
    end
    check_build("abort", cyc, 1'b1);
    exp_q.push_back(1); exp_q.push_back(0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check_drained("abort");
  endtask

  task automatic test_reset_mid();
    // Reset with a symbol held under backpressure: sym_valid must drop without a clock edge.
    bus.sym_ready = 1'b0;
    send_bit(1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.sym_valid !== 1'b0 || bus.sym_out !== '0 || bus.over !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_decode: got sym_valid=%b sym_out=%0d over=%b, required 0 0 0",
               bus.sym_valid, bus.sym_out, bus.over);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.sym_ready = 1'b1;
    for (int i = 0; i < IDX; i++) bus.lens[i] = T_BASIC[i*W +: W];
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (18) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.over, bus.err, bus.bit_ready, bus.sym_valid} !== 4'b0 || bus.sym_out !== '0) begin
      n_bad++;
      $display("FAIL reset_place: got over=%b err=%b bit_ready=%b sym_valid=%b sym_out=%0d, required all 0",
               bus.over, bus.err, bus.bit_ready, bus.sym_valid, bus.sym_out);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    n_vec++;
    if (bus.over !== 1'b0 || bus.err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_place_idle: got over=%b err=%b, required 0 0", bus.over, bus.err);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    bus.sym_ready = 1'b1;
    for (int i = 0; i < IDX; i++) bus.lens[i] = '0;
    test_reset();
    test_basic();
    test_bad_table("oversub", T_OVER);
    test_bad_table("badlen", T_BADLEN);
    test_bad_table("allzero", T_ZERO);
    test_undecodable();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ht_dec.md
Name: ht_dec

Overview:
- Canonical-Huffman decoder; the receive end of the `ht` code-length generator.
- Takes the per-symbol code-length table (`index` entries, `width` bits each) that `ht` produces, and builds canonical decode tables over several cycles.
- Then consumes a serial bitstream and emits one symbol index per decoded codeword.
- Sits downstream of `ht`, sharing its start/over convention.

Parameters:
- index, 8, number of symbols (table entries)
- width, 4, bits per code-length entry
- index_width, $clog2(index), symbol index width
- max_len, 7, longest legal code length; must satisfy max_len <= 2**width-1

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- start  input  1  level/pulse; sampled each edge, begins a table build
- lens  input  [width-1:0] x [0:index-1]  code length per symbol, 0 = unused; must be stable from the start edge until over or err
- over  output  1  level; table built and decoder running
- err  output  1  level; invalid table or undecodable stream
- bit_in  input  1  next stream bit, MSB-first per codeword
- bit_valid  input  1  bit_in valid
- bit_ready  output  1  decoder accepts a bit this cycle
- sym_out  output  index_width  decoded symbol
- sym_valid  output  1  sym_out valid
- sym_ready  input  1  downstream accepts sym_out

Behaviour:
- Reset values (async, immediate): state=IDLE; over=0, err=0, bit_ready=0, sym_valid=0, sym_out=0; all internal tables and counters cleared.
- States: IDLE, COUNT, OFFS, PLACE, DECODE, ERR.
- start=1 sampled in any state goes to COUNT. This aborts any decode in progress: partial codeword, sym_valid, over and err are all cleared on that edge.
- COUNT (index cycles):
  - Cycle i reads lens[i].
  - If lens[i] > max_len, set the bad flag.
  - Otherwise, if lens[i] != 0, increment count[lens[i]].
- OFFS (max_len cycles): for L=1..max_len:
  - offs[L] = running prefix sum of count[1..L-1].
  - Kraft check: left starts at 1; left = 2*left - count[L]; left < 0 means oversubscribed, set bad.
  - After L=max_len, bad is also set if all counts are 0.
- PLACE (index cycles):
  - Cycle i: if lens[i] != 0, write sorted[offs[lens[i]]] = i, then offs[lens[i]]++.
  - Ascending i gives canonical order: within equal length, lower index gets the lower code.
  - Skipped entirely if bad is set; go directly to ERR, same total latency.
- Exit from PLACE:
  - over=1 (good table) or err=1 (bad table) is registered on the edge exactly 2*index+max_len cycles after the start-sampling edge (23 with defaults).
  - State becomes DECODE or ERR on that same edge.
- DECODE:
  - bit_ready = (state==DECODE) && (!sym_valid || sym_ready).
  - Registers code, first, idx, len; all zero at codeword start.
  - On each bit handshake:
    - c = (code<<1)|bit_in
    - f = first<<1 (first is cleared to 0 at codeword start)
    - len++
    - cnt = count[len]
  - If c - f < cnt (unsigned, c >= f):
    - sym_out <= sorted[idx + c - f]; sym_valid <= 1 on this edge.
    - Reset code, first, idx and len to 0.
  - Else: idx += cnt; first <= f + cnt; code <= c.
  - If no match and len reaches max_len: go to ERR, err=1, bit_ready=0.
  - sym_valid clears on sym_valid && sym_ready, unless a new symbol is produced on the same edge, in which case it stays 1 with the new sym_out.
- Latency: sym_valid rises on the edge that accepts the codeword's last bit. Throughput is one bit per cycle with no bubbles while sym_ready=1.
- ERR: bit_ready=0, sym_valid=0, over=0, err=1. Held until start or rst.
- IDLE: bit_ready=0; over=err=0.
- Arithmetic widths: code, first, and left are max_len+1 bits. count and offs are index_width+1 bits.

Test Plan:
- Basic decode:
  - Stimulus: rst released, start with lens={2,1,3,3,0,0,0,0}.
  - Required: over=1 exactly 23 cycles after the start edge. Codes are sym1=0, sym0=10, sym2=110, sym3=111.
  - Then stream 0,1,0,1,1,1,1,1,0 with sym_ready=1 → sym_out sequence 1,0,3,2, each valid on the edge of the codeword's last bit.
- Oversubscribed table: lens={1,1,1,0,0,0,0,0} → err=1 at cycle 23, over=0, bit_ready=0.
- Bad lengths:
  - lens[5]=8 (> max_len) → err at 23.
  - All-zero lens → err at 23.
- Undecodable stream: lens={1,2,0,0,0,0,0,0} (sym0=0, sym1=10); stream seven 1s → err rises on the 7th bit handshake, and no sym_valid ever asserts.
- Backpressure: basic table; hold sym_ready=0 after first symbol → sym_valid stays 1, sym_out stays 1, bit_ready=0. Release → next symbols 0,3,2 with none lost or duplicated.
- Abort and reset:
  - Assert start mid-codeword in DECODE (after bits 1,1) → over drops, partial code is discarded, rebuild takes 23 cycles, and a fresh stream decodes correctly.
  - Assert rst mid-PLACE → all outputs return to 0 immediately.
